pc_stack_unit: RTL and testbench

//   Parametrised program counter with conditional jump and a hardware call/return stack.

---
 rtl/pc_stack_unit.sv | 131 +++++++++++++
 tb/tb_pc_stack_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: parametrised program counter with conditional jumps and a
// LIFO return-address stack for CALL/RET.
//
// Ports:
//   CLK      clock, all state changes on the rising edge
//   CLR      asynchronous active-high reset (clears PC, SP, ERR, stack)
//   EN       1 = execute OP this cycle, 0 = freeze PC/SP/stack/ERR
//   OP       operation: INC, JMP, JC, JNC, CALL, RET, HOLD, (reserved=INC)
//   Im       jump / call target
//   COND     branch condition, only looked at by JC/JNC
//   CLR_ERR  clears the sticky error flag, independent of EN
//   Out      current PC (registered)
//   SP       stack occupancy 0..STACK_DEPTH (registered)
//   FULL     SP == STACK_DEPTH (combinational)
//   EMPTY    SP == 0 (combinational)
//   ERR      sticky flag: CALL on full or RET on empty
module pc_stack_unit #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned SPW        = $clog2(STACK_DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] Im,
  input  logic             COND,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] Out,
  output logic [SPW-1:0]   SP,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ERR
);

  // Stack index width; at least one bit so a depth-1 stack still has an index.
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JC   = 3'b010;
  localparam logic [2:0] OP_JNC  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HOLD = 3'b110;

  logic [WIDTH-1:0] stack [STACK_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] out_d;
  logic [SPW-1:0]   sp_d;
  logic             err_d;
  logic             push;
  logic             illegal;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;

  // Occupancy flags straight from the registered stack pointer.
  assign FULL  = (SP == SPW'(STACK_DEPTH));
  assign EMPTY = (SP == '0);

  assign pc_inc   = WIDTH'(Out + WIDTH'(1));
  assign push_idx = AW'(SP);
  assign pop_idx  = AW'(SP - SPW'(1));

  // Next-state decode; COND is only consulted by the two branch ops.
  always_comb begin
    out_d   = Out;
    sp_d    = SP;
    err_d   = ERR;
    push    = 1'b0;
    illegal = 1'b0;

    if (EN) begin
      case (OP)
        OP_INC:  out_d = pc_inc;
        OP_JMP:  out_d = Im;
        OP_JC:   out_d = COND ? Im : pc_inc;
        OP_JNC:  out_d = COND ? pc_inc : Im;
        OP_CALL: begin
          if (!FULL) begin
            push  = 1'b1;
            sp_d  = SPW'(SP + SPW'(1));
            out_d = Im;
          end else begin
            out_d   = pc_inc;
            illegal = 1'b1;
          end
        end
        OP_RET: begin
          if (!EMPTY) begin
            out_d = stack[pop_idx];
            sp_d  = SPW'(SP - SPW'(1));
          end else begin
            out_d   = pc_inc;
            illegal = 1'b1;
          end
        end
        OP_HOLD: out_d = Out;
        default: out_d = pc_inc;
      endcase
    end

    // A new error in the same cycle as a clear must leave ERR set.
    if (CLR_ERR) err_d = 1'b0;
    if (illegal) err_d = 1'b1;
  end

  // PC, stack pointer and error flag.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      Out <= '0;
      SP  <= '0;
      ERR <= 1'b0;
    end else begin
      Out <= out_d;
      SP  <= sp_d;
      ERR <= err_d;
    end
  end

  // Return-address storage; reset wipes every entry so no stale address survives.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (push) begin
      stack[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Testbench for pc_stack_unit: directed scenarios with literal expectations
// plus randomized traffic, all checked against a queue-based reference model.
module tb_pc_stack_unit;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SPW   = $clog2(DEPTH + 1);
  localparam int          MASK  = (1 << WIDTH) - 1;

  logic             CLK = 1'b0;
  logic             CLR = 1'b0;
  logic             EN = 1'b0;
  logic [2:0]       OP = 3'd0;
  logic [WIDTH-1:0] Im = '0;
  logic             COND = 1'b0;
  logic             CLR_ERR = 1'b0;
  logic [WIDTH-1:0] Out;
  logic [SPW-1:0]   SP;
  logic             FULL;
  logic             EMPTY;
  logic             ERR;

  pc_stack_unit #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .OP(OP), .Im(Im), .COND(COND),
    .CLR_ERR(CLR_ERR), .Out(Out), .SP(SP), .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int tests  = 0;
  int failed = 0;

  // Reference model: PC as an integer, stack as a queue, error as a bit.
  int m_pc;
  int m_q[$];
  bit m_err;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("out",   int'(Out),   m_pc);
    chk("sp",    int'(SP),    m_q.size());
    chk("full",  int'(FULL),  int'(m_q.size() == DEPTH));
    chk("empty", int'(EMPTY), int'(m_q.size() == 0));
    chk("err",   int'(ERR),   int'(m_err));
  endtask

  task automatic model_step(input bit en, input int op, input int im,
                            input bit cond, input bit clr_err);
    int n;
    bit bad;
    n   = (m_pc + 1) & MASK;
    bad = 0;
    if (en) begin
      case (op)
        1: m_pc = im;
        2: m_pc = cond ? im : n;
        3: m_pc = cond ? n : im;
        4: if (m_q.size() < DEPTH) begin m_q.push_back(n); m_pc = im; end
           else begin m_pc = n; bad = 1; end
        5: if (m_q.size() > 0) m_pc = m_q.pop_back();
           else begin m_pc = n; bad = 1; end
        6: ;
        default: m_pc = n;
      endcase
    end
    if (clr_err) m_err = 0;
    if (bad) m_err = 1;
  endtask

  // One clock: drive on the falling edge, update model on the rising edge, sample 1ns later.
  task automatic step(input bit en, input int op, input int im,
                      input bit cond, input bit clr_err);
    @(negedge CLK);
    EN = en; OP = 3'(op); Im = WIDTH'(im); COND = cond; CLR_ERR = clr_err;
    @(posedge CLK);
    model_step(en, op, im, cond, clr_err);
    #1;
    compare_model();
  endtask

  // Async reset pulse entirely between edges; outputs must clear without a clock.
  task automatic pulse_reset();
    @(negedge CLK);
    EN = 0; CLR_ERR = 0;
    CLR = 1'b1;
    #1;
    m_pc = 0; m_q.delete(); m_err = 0;
    compare_model();
    #1;
    CLR = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_pc = 0; m_err = 0;
    CLR = 1'b1;
    #3;
    CLR = 1'b0;

    // Reset values
    pulse_reset();
    chk("rst_out", int'(Out), 0);
    chk("rst_sp", int'(SP), 0);
    chk("rst_empty", int'(EMPTY), 1);
    chk("rst_full", int'(FULL), 0);
    chk("rst_err", int'(ERR), 0);

    // Wrap and hold
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0, 0);
      chk("wrap_out", int'(Out), (i + 1) % 16);
    end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("en0_out", int'(Out), 1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 6, 9, 1, 0);
      chk("hold_out", int'(Out), 1);
    end

    // Branches
    step(1, 1, 5, 0, 0);
    step(1, 2, 9, 1, 0);  chk("jc_taken", int'(Out), 9);
    step(1, 2, 2, 0, 0);  chk("jc_not", int'(Out), 10);
    step(1, 3, 3, 0, 0);  chk("jnc_taken", int'(Out), 3);
    step(1, 3, 7, 1, 0);  chk("jnc_not", int'(Out), 4);
    step(1, 1, 12, 0, 0); chk("jmp", int'(Out), 12);

    // Nested calls and returns
    step(1, 1, 2, 0, 0);
    step(1, 4, 8, 0, 0);
    step(1, 4, 12, 0, 0);
    step(1, 4, 4, 0, 0);
    chk("nest_sp", int'(SP), 3);
    chk("nest_out", int'(Out), 4);
    step(1, 5, 0, 0, 0); chk("ret1", int'(Out), 13);
    step(1, 5, 0, 0, 0); chk("ret2", int'(Out), 9);
    step(1, 5, 0, 0, 0); chk("ret3", int'(Out), 3);
    chk("nest_empty", int'(EMPTY), 1);

    // Overflow / underflow
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1, 4, 3 * i + 1, 0, 0);
    chk("ovf_full", int'(FULL), 1);
    step(1, 1, 7, 0, 0);
    step(1, 4, 14, 0, 0);
    chk("ovf_out", int'(Out), 8);
    chk("ovf_sp", int'(SP), 4);
    chk("ovf_err", int'(ERR), 1);
    step(0, 0, 0, 0, 1);
    chk("clr_err", int'(ERR), 0);
    step(1, 4, 14, 0, 1);
    chk("set_wins", int'(ERR), 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 5, 0, 0, 0);
    chk("unf_empty", int'(EMPTY), 1);
    chk("unf_err0", int'(ERR), 0);
    step(1, 5, 0, 0, 0);
    chk("unf_out", int'(Out), 2);
    chk("unf_err", int'(ERR), 1);

    // Reset mid-call
    step(0, 0, 0, 0, 1);
    step(1, 4, 6, 0, 0);
    step(1, 4, 9, 0, 0);
    chk("mid_sp", int'(SP), 2);
    pulse_reset();
    chk("mid_rst_sp", int'(SP), 0);
    chk("mid_rst_out", int'(Out), 0);
    step(1, 5, 0, 0, 0);
    chk("mid_ret_err", int'(ERR), 1);
    chk("mid_ret_out", int'(Out), 1);
    pulse_reset();
    step(1, 0, 0, 0, 0);
    chk("post_rst_inc", int'(Out), 1);

    // Randomized traffic, CALL/RET weighted so the stack hits both limits
    for (int i = 0; i < 2000; i++) begin
      int r;
      int op;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        pulse_reset();
      end else begin
        r  = int'($urandom_range(0, 9));
        op = (r < 3) ? 4 : (r < 6) ? 5 : int'($urandom_range(0, 7));
        step($urandom_range(0, 9) != 0, op, int'($urandom_range(0, MASK)),
             1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
